vid_out_fifo: RTL and testbench

//  Elastic pixel buffer directly downstream of the RGB processing top level (filter pipeline output).

---
 rtl/vid_out_fifo.sv | 105 ++++++++++
 tb/tb_vid_out_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vid_out_fifo.sv
// Elastic {r,g,b,hsync,vsync,vde} pixel FIFO with fill level and high-water mark.
// Define VID_OUT_FIFO_FALLTHROUGH_EN for a zero-latency bypass when empty.
module vid_out_fifo #(
  parameter int Depth = 16,
  localparam int FillWidth = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           r_i,
  input  logic [7:0]           g_i,
  input  logic [7:0]           b_i,
  input  logic                 hsync_i,
  input  logic                 vsync_i,
  input  logic                 vde_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [7:0]           r_o,
  output logic [7:0]           g_o,
  output logic [7:0]           b_o,
  output logic                 hsync_o,
  output logic                 vsync_o,
  output logic                 vde_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [FillWidth-1:0] fill_o,
  output logic [FillWidth-1:0] max_fill_o,
  input  logic                 clr_max_i
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [FillWidth-1:0] FullLvl = FillWidth'(Depth);

  typedef logic [26:0] word_t;

  word_t                mem [Depth];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [FillWidth-1:0] fill;
  logic [FillWidth-1:0] max_fill;
  logic [FillWidth-1:0] fill_next;

  word_t in_word;
  word_t out_word;
  logic  empty;
  logic  push;
  logic  pop;
  logic  wr_en;
  logic  rd_en;

  assign in_word = {r_i, g_i, b_i, hsync_i, vsync_i, vde_i};
  assign empty   = (fill == '0);
  assign ready_o = (fill != FullLvl);
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

`ifdef VID_OUT_FIFO_FALLTHROUGH_EN
  // A word offered while empty and taken at once never touches storage.
  assign valid_o  = empty ? valid_i : 1'b1;
  assign out_word = empty ? in_word : mem[rd_ptr];
  assign wr_en    = push & ~(empty & ready_i);
  assign rd_en    = pop & ~empty;
`else
  assign valid_o  = ~empty;
  assign out_word = mem[rd_ptr];
  assign wr_en    = push;
  assign rd_en    = pop;
`endif

  assign {r_o, g_o, b_o, hsync_o, vsync_o, vde_o} = out_word;

  assign fill_next = fill + FillWidth'(wr_en) - FillWidth'(rd_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= in_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      max_fill <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      fill <= fill_next;
      // Clear restarts tracking from the level this cycle leaves behind.
      if (clr_max_i) begin
        max_fill <= fill_next;
      end else if (fill_next > max_fill) begin
        max_fill <= fill_next;
      end
    end
  end

  assign fill_o     = fill;
  assign max_fill_o = max_fill;

endmodule

// File: tb/tb_vid_out_fifo.sv
// Randomized bench for vid_out_fifo with a queue-based reference model.
module tb_vid_out_fifo;

  localparam int Depth = 16;
  localparam int FW = $clog2(Depth + 1);

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [26:0]   in_word = '0;
  logic          valid_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          clr_max_i = 1'b0;
  logic          ready_o, valid_o;
  logic [7:0]    r_o, g_o, b_o;
  logic          hsync_o, vsync_o, vde_o;
  logic [FW-1:0] fill_o, max_fill_o;

  int ncmp = 0;
  int nerr = 0;

  logic [26:0] q[$];
  int          m_max = 0;

  always #5 clk = ~clk;

  vid_out_fifo #(.Depth(Depth)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .r_i(in_word[26:19]), .g_i(in_word[18:11]), .b_i(in_word[10:3]),
    .hsync_i(in_word[2]), .vsync_i(in_word[1]), .vde_i(in_word[0]),
    .valid_i(valid_i), .ready_o(ready_o),
    .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .vde_o(vde_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .fill_o(fill_o), .max_fill_o(max_fill_o), .clr_max_i(clr_max_i)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored words plus a running maximum.
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      q.delete();
      m_max = 0;
    end else begin
      automatic int  n = q.size();
      automatic bit  acc = valid_i && (n < Depth);
      automatic bit  take = ready_i && (n > 0);
`ifdef VID_OUT_FIFO_FALLTHROUGH_EN
      if (n == 0 && ready_i) acc = 1'b0;
`endif
      if (take) void'(q.pop_front());
      if (acc) q.push_back(in_word);
      if (clr_max_i || q.size() > m_max) m_max = q.size();
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      automatic int n = q.size();
      chk("fill", 32'(fill_o), 32'(n));
      chk("max_fill", 32'(max_fill_o), 32'(m_max));
      chk("ready_o", 32'(ready_o), 32'(n != Depth));
`ifdef VID_OUT_FIFO_FALLTHROUGH_EN
      chk("valid_o", 32'(valid_o), 32'((n != 0) || valid_i));
      if (n == 0 && valid_i)
        chk("bypass", 32'({r_o, g_o, b_o, hsync_o, vsync_o, vde_o}),
            32'(in_word));
`else
      chk("valid_o", 32'(valid_o), 32'(n != 0));
`endif
      if (n != 0)
        chk("data", 32'({r_o, g_o, b_o, hsync_o, vsync_o, vde_o}),
            32'(q[0]));
    end
  end

  task automatic step(input logic v, input logic rdy,
                      input logic [26:0] w, input logic clr = 1'b0);
    valid_i   = v;
    ready_i   = rdy;
    in_word   = w;
    clr_max_i = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [26:0] mk(input int r);
    return {8'(r), 8'(r + 1), 8'(r + 2), 3'(r)};
  endfunction

  task automatic drain(input int limit);
    int k = 0;
    while (fill_o != '0 && k < limit) begin
      step(1'b0, 1'b1, '0);
      k++;
    end
    chk("drain_done", 32'(fill_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rst_fill", 32'(fill_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_max", 32'(max_fill_o), 32'd0);
    @(posedge clk);
    #1;

    // Fill to full, then offer a held 17th word
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, mk(i));
    @(negedge clk);
    chk("full_fill", 32'(fill_o), 32'd16);
    chk("full_ready", 32'(ready_o), 32'd0);
    chk("full_max", 32'(max_fill_o), 32'd16);
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, mk(16));
    step(1'b1, 1'b0, mk(16));
    chk("held_fill", 32'(fill_o), 32'd16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      chk("drain_r", 32'(r_o), 32'(i));
      step(1'b0, 1'b1, '0);
    end
    chk("drained_valid", 32'(valid_o), 32'd0);
    chk("drained_fill", 32'(fill_o), 32'd0);
    chk("drained_max", 32'(max_fill_o), 32'd16);

    // Simultaneous push and pop while full
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, mk(100 + i));
    step(1'b1, 1'b1, mk(200));
    chk("fullpp_fill", 32'(fill_o), 32'd15);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, mk(201 + i));
      chk("flow_fill", 32'(fill_o), 32'd15);
    end
    drain(40);

    // High-water clear with concurrent push
    step(1'b0, 1'b0, '0, 1'b1);
    chk("clr_zero", 32'(max_fill_o), 32'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, mk(50 + i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
    chk("pre_clr_fill", 32'(fill_o), 32'd7);
    chk("pre_clr_max", 32'(max_fill_o), 32'd12);
    step(1'b1, 1'b0, mk(70), 1'b1);
    chk("clr_max", 32'(max_fill_o), 32'd8);
    drain(40);

    // Random video-like stream with random back-pressure
    for (int i = 0; i < 4000; i++) begin
      logic [26:0] w;
      w = {8'($urandom), 8'($urandom), 8'($urandom),
           1'((i % 97) < 8), 1'((i % 1500) < 3), 1'((i % 97) >= 12)};
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
           w, 1'($urandom_range(0, 199) == 0));
    end
    drain(60);

`ifdef VID_OUT_FIFO_FALLTHROUGH_EN
    valid_i = 1'b1;
    ready_i = 1'b1;
    in_word = mk(9);
    #1;
    chk("ft_valid", 32'(valid_o), 32'd1);
    @(posedge clk);
    #1;
    chk("ft_fill", 32'(fill_o), 32'd0);
`endif

    // Reset mid-stream with five words stored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, mk(30 + i));
    chk("pre_rst_fill", 32'(fill_o), 32'd5);
    valid_i = 1'b0;
    in_word = '0;
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 32'd0);
    chk("mid_rst_ready", 32'(ready_o), 32'd1);
    chk("mid_rst_fill", 32'(fill_o), 32'd0);
    chk("mid_rst_max", 32'(max_fill_o), 32'd0);
    chk("mid_rst_rgb", 32'({r_o, g_o, b_o}), 32'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step(1'b1, 1'b0, mk(77));
    step(1'b0, 1'b1, '0);
    chk("post_rst_fill", 32'(fill_o), 32'd0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
